// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle for the multi-cycle multiply/divide unit.
// master drives operations and takes results, slave is the execution unit.
interface alu_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       aluctl;
   logic             op_unsigned;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_by_zero;
   logic             op_err;

   modport master (
      output in_valid, aluctl, op_unsigned, op_a, op_b, flush, out_ready,
      input  in_ready, out_valid, res_hi, res_lo, div_by_zero, op_err
   );

   modport slave (
      input  in_valid, aluctl, op_unsigned, op_a, op_b, flush, out_ready,
      output in_ready, out_valid, res_hi, res_lo, div_by_zero, op_err
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative shift-add multiply / restoring divide for the EX stage, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module alu_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst_n,
   alu_muldiv_unit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [3:0] OP_MUL  = 4'b0110;
   localparam logic [3:0] OP_DIV  = 4'b0111;
   localparam logic [3:0] OP_DIVU = 4'b1000;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q;
   logic               neg_q;
   logic               rneg_q;
   // mul: acc = partial product, mcand = shifted multiplicand
   // div: acc = {remainder, dividend/quotient}, mcand[WIDTH-1:0] = divisor
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH-1:0]   res_hi_q;
   logic [WIDTH-1:0]   res_lo_q;
   logic               out_valid_q;
   logic               dbz_q;
   logic               err_q;

   logic             is_mul, is_dv, sgn, b_zero;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign is_mul = (bus.aluctl == OP_MUL);
   assign is_dv  = (bus.aluctl == OP_DIV) || (bus.aluctl == OP_DIVU);
   assign sgn    = (bus.aluctl == OP_DIV) || (is_mul && !bus.op_unsigned);
   assign b_zero = (bus.op_b == '0);
   assign abs_a  = (sgn && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
   assign abs_b  = (sgn && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

   logic [2*WIDTH-1:0] mul_sum_d;
   logic [WIDTH-1:0]   rem_w, quo_w, rem_shift_d, rem_d;
   logic               ge_d;

   assign mul_sum_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign rem_w     = acc_q[2*WIDTH-1:WIDTH];
   assign quo_w     = acc_q[WIDTH-1:0];
   // The compare sees the bit shifted out of the remainder; the subtraction
   // can work modulo 2^WIDTH because the true difference is below the divisor.
   assign rem_shift_d = {rem_w[WIDTH-2:0], quo_w[WIDTH-1]};
   assign ge_d        = {rem_w, quo_w[WIDTH-1]} >= {1'b0, mcand_q[WIDTH-1:0]};
   assign rem_d       = ge_d ? (rem_shift_d - mcand_q[WIDTH-1:0]) : rem_shift_d;

   logic calc_last;
`ifdef MULDIV_EARLY_OUT_EN
   assign calc_last = (cnt_q == '0) || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
   assign calc_last = (cnt_q == '0);
`endif

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = neg_q  ? -acc_q : acc_q;
   assign quo_fix  = neg_q  ? -quo_w : quo_w;
   assign rem_fix  = rneg_q ? -rem_w : rem_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         neg_q       <= 1'b0;
         rneg_q      <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
         err_q       <= 1'b0;
      end else if (bus.flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dbz_q <= 1'b0;
                  err_q <= 1'b0;
                  if (is_mul || is_dv) begin
                     is_div_q <= is_dv;
                     neg_q    <= sgn && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                     rneg_q   <= sgn && bus.op_a[WIDTH-1];
                     acc_q    <= is_dv ? {{WIDTH{1'b0}}, abs_a} : '0;
                     mcand_q  <= {{WIDTH{1'b0}}, (is_dv ? abs_b : abs_a)};
                     mplier_q <= abs_b;
                     cnt_q    <= CW'(WIDTH-1);
                     if (is_dv && b_zero) begin
                        res_hi_q    <= bus.op_a;
                        res_lo_q    <= '1;
                        dbz_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                     end
`ifdef MULDIV_EARLY_OUT_EN
                     else if (b_zero) begin
                        state_q <= FIXUP;
                     end
`endif
                     else begin
                        state_q <= CALC;
                     end
                  end else begin
                     res_hi_q    <= '0;
                     res_lo_q    <= '0;
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            CALC: begin
               if (is_div_q) begin
                  acc_q <= {rem_d, quo_w[WIDTH-2:0], ge_d};
               end else begin
                  acc_q    <= mul_sum_d;
                  mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                  mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
               end
               cnt_q <= cnt_q - 1'b1;
               if (calc_last) state_q <= FIXUP;
            end
            FIXUP: begin
               if (is_div_q) begin
                  res_hi_q <= rem_fix;
                  res_lo_q <= quo_fix;
               end else begin
                  res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  res_lo_q <= prod_fix[WIDTH-1:0];
               end
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = out_valid_q;
   assign bus.res_hi      = res_hi_q;
   assign bus.res_lo      = res_lo_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.op_err      = err_q;
endmodule
